// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code counter: the per-cycle operation
// encoding and reference-width Gray conversion helpers.
package gray_pkg;

  // Helpers run at a fixed wide width. Zero-extending a narrower value gives
  // the same low-order result, so any SIZE up to this width can use them.
  localparam int GRAY_MAX_W = 32;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_CLEAR = 2'd1,
    OP_LOAD  = 2'd2,
    OP_STEP  = 2'd3
  } gray_op_e;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] gray2bin_f(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/bin2gray.sv
// Combinational SIZE-bit binary to reflected-Gray encoder.
module bin2gray #(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0] bin_i,
  output logic [SIZE-1:0] gray_o
);

  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/gray_counter.sv
// Up/down Gray-code counter with clear, load and wrap-or-saturate range ends.
// The Gray output is encoded from the next binary value and registered, so it
// moves one bit per step and never glitches.
module gray_counter
  import gray_pkg::*;
#(
  parameter int SIZE = 8,
  parameter bit WRAP = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            load,
  input  logic [SIZE-1:0] load_bin,
  input  logic            en,
  input  logic            up,
  output logic [SIZE-1:0] gray,
  output logic [SIZE-1:0] bin,
  output logic            at_max,
  output logic            at_min,
  output logic            wrap
);

  localparam logic [SIZE-1:0] MAX_VAL = '1;
  localparam logic [SIZE-1:0] ONE     = {{(SIZE-1){1'b0}}, 1'b1};

  gray_op_e        op;
  logic [SIZE-1:0] bin_q, bin_d;
  logic [SIZE-1:0] gray_q, gray_d;
  logic            wrap_q, wrap_d;

  always_comb begin
    op = OP_HOLD;
    if (clear)     op = OP_CLEAR;
    else if (load) op = OP_LOAD;
    else if (en)   op = OP_STEP;
  end

  // At a range end, wrap_d flags the event whether the count wraps or holds.
  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    case (op)
      OP_CLEAR: bin_d = '0;
      OP_LOAD:  bin_d = load_bin;
      OP_STEP: begin
        if (up) begin
          if (bin_q == MAX_VAL) begin
            wrap_d = 1'b1;
            if (WRAP) bin_d = '0;
          end else begin
            bin_d = bin_q + ONE;
          end
        end else begin
          if (bin_q == '0) begin
            wrap_d = 1'b1;
            if (WRAP) bin_d = MAX_VAL;
          end else begin
            bin_d = bin_q - ONE;
          end
        end
      end
      default: bin_d = bin_q;
    endcase
  end

  bin2gray #(.SIZE(SIZE)) u_enc (
    .bin_i  (bin_d),
    .gray_o (gray_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin    = bin_q;
  assign gray   = gray_q;
  assign wrap   = wrap_q;
  assign at_max = (bin_q == MAX_VAL);
  assign at_min = (bin_q == '0);

endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter: three instances (5-bit wrap, 5-bit saturate,
// 8-bit wrap) share stimulus and are checked against a range-arithmetic model.
module tb_gray_counter;
  import gray_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0, clear = 1'b0, load = 1'b0, en = 1'b0, up = 1'b0;
  logic [7:0] load_bin = '0;

  logic [4:0] g0, b0, g1, b1;
  logic [7:0] g2, b2;
  logic       mx0, mn0, wr0, mx1, mn1, wr1, mx2, mn2, wr2;

  int tests = 0;
  int fails = 0;

  int sz[3]    = '{5, 5, 8};
  bit wmode[3] = '{1'b1, 1'b0, 1'b1};
  int exp_bin[3];
  bit exp_wrap[3];
  bit changed[3];
  logic [7:0] prev_gray[3];

  always #5 clk = ~clk;

  gray_counter #(.SIZE(5), .WRAP(1'b1)) u_w5 (
    .clk(clk), .rst(rst), .clear(clear), .load(load), .load_bin(load_bin[4:0]),
    .en(en), .up(up), .gray(g0), .bin(b0), .at_max(mx0), .at_min(mn0), .wrap(wr0));

  gray_counter #(.SIZE(5), .WRAP(1'b0)) u_s5 (
    .clk(clk), .rst(rst), .clear(clear), .load(load), .load_bin(load_bin[4:0]),
    .en(en), .up(up), .gray(g1), .bin(b1), .at_max(mx1), .at_min(mn1), .wrap(wr1));

  gray_counter #(.SIZE(8), .WRAP(1'b1)) u_w8 (
    .clk(clk), .rst(rst), .clear(clear), .load(load), .load_bin(load_bin),
    .en(en), .up(up), .gray(g2), .bin(b2), .at_max(mx2), .at_min(mn2), .wrap(wr2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: counting is plain integer arithmetic within [0, 2^size-1].
  task automatic model_update(input bit r, c, l, input logic [7:0] lb, input bit e, u);
    for (int k = 0; k < 3; k++) begin
      int mx = (1 << sz[k]) - 1;
      int nb = exp_bin[k];
      bit nw = 1'b0;
      if (r || c) nb = 0;
      else if (l) nb = int'(lb) % (mx + 1);
      else if (e) begin
        if (u) begin
          if (exp_bin[k] == mx) begin nw = 1'b1; nb = wmode[k] ? 0 : mx; end
          else nb = exp_bin[k] + 1;
        end else begin
          if (exp_bin[k] == 0) begin nw = 1'b1; nb = wmode[k] ? mx : 0; end
          else nb = exp_bin[k] - 1;
        end
      end
      changed[k]  = (nb != exp_bin[k]);
      exp_bin[k]  = nb;
      exp_wrap[k] = nw;
    end
  endtask

  task automatic check_dut(input int k, input logic [7:0] g, b, input logic mx, mn, wr,
                           input bit stepped);
    int eb = exp_bin[k];
    int emax = (1 << sz[k]) - 1;
    chk($sformatf("bin[%0d]", k), 32'(b), 32'(eb));
    chk($sformatf("gray[%0d]", k), 32'(g), 32'(eb ^ (eb >> 1)));
    chk($sformatf("gray2bin[%0d]", k), gray2bin_f(32'(g)), 32'(eb));
    chk($sformatf("wrap[%0d]", k), 32'(wr), 32'(exp_wrap[k]));
    chk($sformatf("at_max[%0d]", k), 32'(mx), 32'(eb == emax));
    chk($sformatf("at_min[%0d]", k), 32'(mn), 32'(eb == 0));
    if (stepped && changed[k])
      chk($sformatf("hamming[%0d]", k), 32'($countones(g ^ prev_gray[k])), 32'd1);
    prev_gray[k] = g;
  endtask

  task automatic do_step(input bit r, c, l, input logic [7:0] lb, input bit e, u);
    @(negedge clk);
    rst = r; clear = c; load = l; load_bin = lb; en = e; up = u;
    @(posedge clk);
    model_update(r, c, l, lb, e, u);
    #1;
    check_dut(0, {3'b0, g0}, {3'b0, b0}, mx0, mn0, wr0, e && !r && !c && !l);
    check_dut(1, {3'b0, g1}, {3'b0, b1}, mx1, mn1, wr1, e && !r && !c && !l);
    check_dut(2, g2, b2, mx2, mn2, wr2, e && !r && !c && !l);
  endtask

  initial begin
    logic [4:0] seq_gray[5];
    seq_gray = '{5'b00000, 5'b00001, 5'b00011, 5'b00010, 5'b00110};

    // Reset, then count up four steps against the literal Gray sequence.
    do_step(1, 0, 0, 8'd0, 0, 0);
    do_step(1, 0, 0, 8'd0, 1, 1);
    chk("seq_gray0", 32'(g0), 32'(seq_gray[0]));
    for (int i = 1; i <= 4; i++) begin
      do_step(0, 0, 0, 8'd0, 1, 1);
      chk($sformatf("seq_gray%0d", i), 32'(g0), 32'(seq_gray[i]));
      chk($sformatf("seq_bin%0d", i), 32'(b0), i);
    end

    // Up-direction range end: wrap vs saturate, wrap pulse lasts one cycle.
    do_step(0, 0, 1, 8'hFF, 0, 0);
    chk("load31_gray", 32'(g0), 32'b10000);
    do_step(0, 0, 0, 8'd0, 1, 1);
    chk("wrap_up_bin", 32'(b0), 0);
    do_step(0, 0, 0, 8'd0, 0, 1);

    // Down-direction range end from zero.
    do_step(0, 1, 0, 8'd0, 0, 0);
    do_step(0, 0, 0, 8'd0, 1, 0);
    chk("wrap_dn_gray", 32'(g0), 32'b10000);
    do_step(0, 0, 0, 8'd0, 1, 0);
    do_step(0, 0, 0, 8'd0, 0, 0);

    // Priority rst > clear > load > en.
    do_step(1, 1, 1, 8'd20, 1, 1);
    do_step(0, 1, 1, 8'd20, 1, 1);
    do_step(0, 0, 1, 8'd20, 1, 1);
    chk("prio_load_gray", 32'(g0), 32'b11110);

    // Reset mid-count, then resume from zero.
    do_step(0, 1, 0, 8'd0, 0, 0);
    for (int i = 0; i < 13; i++) do_step(0, 0, 0, 8'd0, 1, 1);
    chk("mid_count13", 32'(b0), 13);
    do_step(1, 0, 0, 8'd0, 1, 1);
    do_step(0, 0, 0, 8'd0, 1, 1);
    chk("resume1", 32'(b0), 1);

    // Randomized mix of all controls.
    for (int i = 0; i < 400; i++) begin
      do_step($urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0,
              $urandom_range(0, 7) == 0, 8'($urandom_range(0, 255)),
              $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
    end

    // Exhaustive walk: 64 up then 64 down from zero.
    do_step(1, 0, 0, 8'd0, 0, 0);
    for (int i = 0; i < 64; i++) do_step(0, 0, 0, 8'd0, 1, 1);
    for (int i = 0; i < 64; i++) do_step(0, 0, 0, 8'd0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Synchronous Gray-code counter that produces the Gray values consumed by the downstream gray2bin converter, e.g. for FIFO read/write pointers.
- Counts internally in binary and registers the Gray encoding, so the Gray output changes exactly one bit per step and never glitches.
- Supports up/down counting, synchronous clear and load, and either wrap or saturate at the range ends.

Parameters:
- SIZE, 8, counter width in bits (SIZE >= 2).
- WRAP, 1, 1 = wrap at range ends; 0 = saturate at range ends.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous zero of the count.
- load  input  1  synchronous load of load_bin.
- load_bin  input  SIZE  binary value to load.
- en  input  1  count enable (one step per cycle).
- up  input  1  direction: 1 = increment, 0 = decrement.
- gray  output  SIZE  registered Gray-coded count.
- bin  output  SIZE  registered binary count (same cycle as gray).
- at_max  output  1  combinational: bin == 2^SIZE-1.
- at_min  output  1  combinational: bin == 0.
- wrap  output  1  registered one-cycle event flag.

Behaviour:
- Reset values: rst=1 at an edge forces bin=0, gray=0, wrap=0, so at_min=1 and at_max=0. Reset overrides all other inputs, including mid-count.
- Priority at each edge: rst > clear > load > en. Lower-priority inputs are ignored in that cycle.
- clear sets bin=0 and gray=0.
- load sets bin=load_bin and gray=load_bin ^ (load_bin>>1).
- Counting, en=1 and up=1:
  - If bin != max, next = bin+1.
  - If bin == max and WRAP=1, next = 0.
  - If bin == max and WRAP=0, the count holds at max.
- Counting, en=1 and up=0: symmetric to up=1, using 0 as the end of range and 2^SIZE-1 as the wrap target.
- en=0 with no clear or load: bin, gray and wrap hold / deassert as below.
- Gray is always computed from the next binary value and registered in the same edge as bin. gray == bin ^ (bin>>1) holds after every edge.
- Latency: one cycle from any input to bin/gray.
- Between consecutive en steps, exactly one bit of gray changes. This includes the wrap steps max->0 and 0->max.
- wrap is asserted in the cycle following an en step that:
  - wrapped (WRAP=1), or
  - was blocked by saturation (WRAP=0).
- wrap is 0 following any cycle with rst, clear, load or en=0, and following any non-boundary step.
- load of an end value followed by an en step toward that end behaves as boundary wrap / saturation on the next edge.
- Direction may change on any cycle; there is no hidden state besides bin.
- Arithmetic is modulo 2^SIZE. There is no carry output beyond wrap.

Decomposition:
- Package gray_pkg holds:
  - function bin2gray(logic [SIZE-1:0]), as a parameterised function via a class or macro per team practice.
  - function gray2bin_f, used as the bench reference model.
- Natural sub-module: bin2gray, a combinational SIZE-bit encoder.
  - gray_counter instantiates it on the next-state binary value.
  - The bench chains gray_counter.gray into gray2bin and checks the result against bin.

Test Plan (SIZE=5 unless noted):
- Reset then count: hold rst=1 for 2 cycles, then en=1, up=1 for 4 cycles -> gray sequence 00000, 00001, 00011, 00010, 00110 and bin 0..4. gray2bin(gray) equals bin every cycle; wrap=0 throughout.
- Wrap up with WRAP=1: load 31 (gray=10000), then one en up step -> bin=0, gray=00000, wrap=1 for exactly one cycle, and exactly one gray bit changed.
- Wrap down and saturate:
  - WRAP=1: from bin=0, en down -> bin=31, gray=10000, wrap=1.
  - WRAP=0: from bin=31, en up -> bin stays 31, wrap=1.
  - WRAP=0: from bin=0, en down -> bin stays 0, wrap=1.
- Priority: assert rst, clear, load=5'd20 and en together -> bin=0. Then clear+load=20+en -> 0. Then load=20+en -> bin=20, gray=11110.
- Reset mid-operation: count to 13, assert rst for one cycle with en=1 -> bin=0, gray=0, wrap=0. Counting resumes from 0 on the next cycle.
- Exhaustive walk: 64 en steps up then 64 down, with SIZE=5 and SIZE=8 -> every step has Hamming distance 1 on gray, and gray == bin^(bin>>1) on every cycle.
